// File: rtl/axi_stall_slice.sv
// Two-entry valid/ready register slice that inserts LFSR-drawn idle gaps after
// each downstream transfer, with transfer and stall statistics.
module axi_stall_slice #(
  parameter int          DATA_W    = 32,
  parameter int          MAX_DELAY = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [CNT_W-1:0]  beats_out,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int          WAIT_W = $clog2(MAX_DELAY) + 1;
  localparam int unsigned MAX_D  = MAX_DELAY;
  // An all-zero seed would lock the LFSR at zero forever.
  localparam logic [15:0] SEED   = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  logic [DATA_W-1:0] mem [2];
  logic              head;
  logic              tail;
  logic [1:0]        count;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic [15:0]       lfsr;
  logic              lfsr_fb;
  logic              push;
  logic              pop;
  int unsigned       draw;

  // Handshake decodes use registered state only, so ready never depends on m_ready.
  assign s_ready = (count != 2'd2);
  assign m_valid = (count != 2'd0) && (wait_cnt == '0);
  assign m_data  = mem[head];
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    draw     = 32'(lfsr[7:0]) % MAX_D;
    wait_nxt = wait_cnt;
    if (!en) begin
      wait_nxt = '0;
    end else if (pop) begin
      wait_nxt = WAIT_W'(draw);
    end else if (wait_cnt != '0) begin
      wait_nxt = wait_cnt - 1'b1;
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the two payload entries are reset as well so m_data reads 0 out of reset.
      mem[0]       <= '0;
      mem[1]       <= '0;
      head         <= 1'b0;
      tail         <= 1'b0;
      count        <= 2'd0;
      wait_cnt     <= '0;
      lfsr         <= SEED;
      beats_out    <= '0;
      stall_cycles <= '0;
    end else begin
      if (push) begin
        mem[tail] <= s_data;
        tail      <= ~tail;
      end
      if (pop) begin
        head      <= ~head;
        lfsr      <= {lfsr[14:0], lfsr_fb};
        beats_out <= beats_out + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      wait_cnt <= wait_nxt;
      if ((count != 2'd0) && (wait_cnt != '0) && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_stall_slice.sv
// Directed bench for axi_stall_slice: reset, throttle sequence, pass-through,
// backpressure, enable drop mid-gap and counter saturation/wrap.
module tb_axi_stall_slice;

  localparam int DATA_W    = 32;
  localparam int MAX_DELAY = 4;
  localparam int CNT_W     = 4;

  logic              clk;
  logic              rst;
  logic              en;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [CNT_W-1:0]  beats_out;
  logic [CNT_W-1:0]  stall_cycles;

  int total;
  int bad;
  int cyc;

  int          pop_cyc [$];
  logic [31:0] pop_dat [$];
  logic [15:0] pop_lfsr[$];

  axi_stall_slice #(
    .DATA_W   (DATA_W),
    .MAX_DELAY(MAX_DELAY),
    .LFSR_SEED(16'hACE1),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .beats_out   (beats_out),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record each transfer (cycle, payload, pre-advance LFSR) just before its edge.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      pop_cyc.push_back(cyc);
      pop_dat.push_back(m_data);
      pop_lfsr.push_back(dut.lfsr);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    pop_cyc.delete();
    pop_dat.delete();
    pop_lfsr.delete();
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    en      = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    clear_log();
  endtask

  task automatic push_beats(input int n, input logic [31:0] base);
    bit acc;
    int guard;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = base + 32'(i);
      guard   = 0;
      do begin
        acc = s_ready;
        step();
        guard++;
      end while (!acc && guard < 200);
      if (!acc) begin
        total++;
        bad++;
        $display("FAIL push_timeout: beat %0d never accepted, required acceptance", i);
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_pops(input int n);
    int guard;
    guard = 0;
    while (pop_dat.size() < n && guard < 300) begin
      step();
      guard++;
    end
    if (pop_dat.size() < n) begin
      total++;
      bad++;
      $display("FAIL pop_timeout: got %0d pops, required %0d", pop_dat.size(), n);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    bit found;
    do_reset();
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rst_s_ready: got %b want 1", s_ready); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
    total++; if (m_data !== 32'h0) begin bad++; $display("FAIL rst_m_data: got %h want 0", m_data); end
    total++; if (dut.lfsr !== 16'hACE1) begin bad++; $display("FAIL rst_lfsr: got %h want ace1", dut.lfsr); end

    // Stream with throttling until the buffer is full and a gap of 2 is pending.
    en = 1'b1; m_ready = 1'b1;
    d = 32'h100; s_data = d; s_valid = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (dut.count == 2'd2 && dut.wait_cnt == 2) begin
        found = 1'b1;
      end else begin
        if (s_ready) begin
          step(); d++; s_data = d;
        end else begin
          step();
        end
      end
    end
    total++; if (!found) begin bad++; $display("FAIL rst_setup: count=2/wait=2 not reached, got count=%0d wait=%0d", dut.count, dut.wait_cnt); end

    #2 rst = 1'b1;
    #1;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL midrst_m_valid: got %b want 0", m_valid); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL midrst_s_ready: got %b want 1", s_ready); end
    total++; if (beats_out !== 4'd0 || stall_cycles !== 4'd0) begin bad++; $display("FAIL midrst_counters: got beats=%0d stall=%0d want 0/0", beats_out, stall_cycles); end
    s_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    clear_log();

    en = 1'b1; m_ready = 1'b1;
    push_beats(2, 32'h200);
    wait_pops(2);
    if (pop_dat.size() >= 2) begin
      total++; if (pop_cyc[1] - pop_cyc[0] - 1 !== 1) begin bad++; $display("FAIL post_rst_gap: got %0d want 1", pop_cyc[1] - pop_cyc[0] - 1); end
      total++; if (pop_lfsr[1] !== 16'h59C3) begin bad++; $display("FAIL post_rst_lfsr: got %h want 59c3", pop_lfsr[1]); end
    end
  endtask

  task automatic test_throttle();
    logic [15:0] exp_lfsr [3];
    int          exp_gap  [3];
    exp_lfsr = '{16'h59C3, 16'hB387, 16'h670F};
    exp_gap  = '{1, 3, 3};
    do_reset();
    en = 1'b1; m_ready = 1'b1;
    push_beats(4, 32'h10);
    wait_pops(4);
    step();
    if (pop_dat.size() >= 4) begin
      for (int i = 0; i < 3; i++) begin
        total++; if (pop_cyc[i+1] - pop_cyc[i] - 1 !== exp_gap[i]) begin bad++; $display("FAIL thr_gap%0d: got %0d want %0d", i, pop_cyc[i+1] - pop_cyc[i] - 1, exp_gap[i]); end
        total++; if (pop_lfsr[i+1] !== exp_lfsr[i]) begin bad++; $display("FAIL thr_lfsr%0d: got %h want %h", i, pop_lfsr[i+1], exp_lfsr[i]); end
      end
      total++; if (pop_dat[3] !== 32'h13) begin bad++; $display("FAIL thr_data3: got %h want 13", pop_dat[3]); end
    end
    total++; if (beats_out !== 4'd4) begin bad++; $display("FAIL thr_beats: got %0d want 4", beats_out); end
    total++; if (stall_cycles !== 4'd7) begin bad++; $display("FAIL thr_stall: got %0d want 7", stall_cycles); end
  endtask

  task automatic test_pass_through();
    bit ready_low;
    do_reset();
    en = 1'b0; m_ready = 1'b1;
    ready_low = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1;
      s_data  = 32'h30 + 32'(i);
      if (s_ready !== 1'b1) ready_low = 1'b1;
      step();
    end
    s_valid = 1'b0;
    wait_pops(8);
    step();
    total++; if (ready_low) begin bad++; $display("FAIL pt_s_ready: got 0 during stream want 1"); end
    if (pop_dat.size() >= 8) begin
      total++; if (pop_cyc[7] - pop_cyc[0] !== 7) begin bad++; $display("FAIL pt_consecutive: got span %0d want 7", pop_cyc[7] - pop_cyc[0]); end
      for (int i = 0; i < 8; i++) begin
        total++; if (pop_dat[i] !== 32'h30 + 32'(i)) begin bad++; $display("FAIL pt_data%0d: got %h want %h", i, pop_dat[i], 32'h30 + 32'(i)); end
      end
    end
    total++; if (stall_cycles !== 4'd0) begin bad++; $display("FAIL pt_stall: got %0d want 0", stall_cycles); end
    total++; if (beats_out !== 4'd8) begin bad++; $display("FAIL pt_beats: got %0d want 8", beats_out); end
  endtask

  task automatic test_backpressure();
    do_reset();
    en = 1'b0; m_ready = 1'b0;
    fork
      push_beats(3, 32'h40);
      begin
        repeat (3) step();
        for (int i = 0; i < 3; i++) begin
          total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL bp_s_ready%0d: got %b want 0", i, s_ready); end
          total++; if (m_valid !== 1'b1 || m_data !== 32'h40) begin bad++; $display("FAIL bp_hold%0d: got v=%b d=%h want v=1 d=40", i, m_valid, m_data); end
          step();
        end
        m_ready = 1'b1;
      end
    join
    wait_pops(3);
    repeat (3) step();
    total++; if (pop_dat.size() !== 3) begin bad++; $display("FAIL bp_count: got %0d pops want 3", pop_dat.size()); end
    if (pop_dat.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        total++; if (pop_dat[i] !== 32'h40 + 32'(i)) begin bad++; $display("FAIL bp_order%0d: got %h want %h", i, pop_dat[i], 32'h40 + 32'(i)); end
      end
    end
  endtask

  task automatic test_en_drop();
    int guard;
    do_reset();
    en = 1'b1; m_ready = 1'b1;
    fork
      push_beats(3, 32'h50);
      begin
        guard = 0;
        while (pop_dat.size() < 2 && guard < 100) begin
          step();
          guard++;
        end
        en = 1'b0;
        total++; if (dut.lfsr !== 16'hB387) begin bad++; $display("FAIL drop_lfsr_gap: got %h want b387", dut.lfsr); end
      end
    join
    wait_pops(3);
    if (pop_dat.size() >= 3) begin
      total++; if (pop_cyc[2] - pop_cyc[1] !== 2) begin bad++; $display("FAIL drop_reassert: got %0d cycles want 2", pop_cyc[2] - pop_cyc[1]); end
      total++; if (pop_lfsr[2] !== 16'hB387) begin bad++; $display("FAIL drop_lfsr_pop: got %h want b387", pop_lfsr[2]); end
    end
    total++; if (dut.lfsr !== 16'h670F) begin bad++; $display("FAIL drop_lfsr_after: got %h want 670f", dut.lfsr); end
  endtask

  task automatic test_saturation();
    do_reset();
    en = 1'b1; m_ready = 1'b1;
    fork
      push_beats(16, 32'h60);
      begin
        wait_pops(8);
        total++; if (stall_cycles !== 4'd13) begin bad++; $display("FAIL sat_stall8: got %0d want 13", stall_cycles); end
        wait_pops(15);
        total++; if (beats_out !== 4'd15) begin bad++; $display("FAIL sat_beats15: got %0d want 15", beats_out); end
        total++; if (stall_cycles !== 4'd15) begin bad++; $display("FAIL sat_stall15: got %0d want 15", stall_cycles); end
        wait_pops(16);
        total++; if (beats_out !== 4'd0) begin bad++; $display("FAIL sat_wrap: got %0d want 0", beats_out); end
      end
    join
    repeat (4) step();
    total++; if (stall_cycles !== 4'd15) begin bad++; $display("FAIL sat_hold: got %0d want 15", stall_cycles); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    test_reset();
    test_throttle();
    test_pass_through();
    test_backpressure();
    test_en_drop();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
